// File: rtl/img_mem_pkg.sv
// Shared constants and types for the image memory arbiter.
// Frame geometry is 160x120 8-bit grey pixels in a single-port RAM.
package img_mem_pkg;

  localparam int ADDR_W               = 15;
  localparam int DATA_W               = 8;
  localparam int DEPTH                = 19200;
  localparam int STARVE_LIMIT_DEFAULT = 1024;

  localparam logic [ADDR_W-1:0] LAST_FILL_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_FILL = 2'd2,
    GNT_HOST = 2'd3
  } grant_t;

  // Counter width able to hold the saturation value itself.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Display-read, host-write and memory-side signals of the image memory arbiter.
// slave = arbiter view; master = the surrounding system (VGA mapper, host, RAM).
interface image_mem_arbiter_if;
  import img_mem_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/img_fill_seq.sv
// Full-frame fill sequencer: walks addresses 0..DEPTH-1 writing a latched value,
// advancing only on cycles the arbiter actually grants it the memory.
module img_fill_seq
  import img_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              advance_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  fill_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] value_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FILL;
            addr_q  <= '0;
            value_q <= value_i;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          // Address only moves when the write really happened this cycle.
          if (advance_i) begin
            if (addr_q == LAST_FILL_ADDR) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          addr_q  <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_o  = busy_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign addr_o = addr_q;
  assign data_o = value_q;

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: display > fill > host, display never stalled.
// Optional IMG_VBLANK_WR_ONLY_EN restricts host and fill writes to vertical blanking.
module image_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank_i,
  input  logic              fill_start_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              host_starved_o,
  image_mem_arbiter_if.slave bus
);

  localparam int               CNT_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic              write_window;
  logic              fill_req;
  logic              fill_busy;
  logic              fill_done;
  logic              fill_adv;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              host_accept;
  grant_t            grant;

  logic [CNT_W-1:0]  starve_cnt_q;
  logic [CNT_W-1:0]  starve_cnt_d;
  logic              host_starved_q;
  logic              disp_valid_q;

`ifdef IMG_VBLANK_WR_ONLY_EN
  assign write_window = vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign write_window  = 1'b1;
`endif

  img_fill_seq u_fill_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (fill_start_i),
    .value_i   (fill_value_i),
    .advance_i (fill_adv),
    .req_o     (fill_req),
    .addr_o    (fill_addr),
    .data_o    (fill_data),
    .busy_o    (fill_busy),
    .done_o    (fill_done)
  );

  // Gated by rst_n so nothing reaches the RAM while reset is held.
  assign bus.wr_ready = rst_n & ~bus.disp_req & ~fill_busy & write_window;
  assign host_accept  = bus.wr_valid & bus.wr_ready;

  always_comb begin
    grant = GNT_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (bus.disp_req) begin
      grant = GNT_DISP;
    end else if (fill_req && write_window) begin
      grant = GNT_FILL;
    end else if (host_accept) begin
      grant = GNT_HOST;
    end
  end

  assign fill_adv = (grant == GNT_FILL);

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (grant)
      GNT_DISP: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end
      GNT_FILL: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = fill_addr;
        bus.mem_wdata = fill_data;
      end
      GNT_HOST: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.wr_addr;
        bus.mem_wdata = bus.wr_data;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  // Blocked-streak length; any accepted write or idle host resets it.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.wr_valid && !bus.wr_ready) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q   <= '0;
      host_starved_q <= 1'b0;
      disp_valid_q   <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      host_starved_q <= (starve_cnt_d == CNT_MAX);
      disp_valid_q   <= bus.disp_req;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = bus.mem_rdata;
  assign fill_busy_o    = fill_busy;
  assign fill_done_o    = fill_done;
  assign host_starved_o = host_starved_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Self-checking bench for image_mem_arbiter (default build, vblank ignored).
// Includes a RAM harness with 1-cycle read latency and a frame-level reference model.
module tb_image_mem_arbiter;
  import img_mem_pkg::*;

  localparam int LIMIT = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vblank = 1'b0;
  logic              fill_start = 1'b0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              fill_busy;
  logic              fill_done;
  logic              host_starved;

  image_mem_arbiter_if bus();

  image_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vblank_i       (vblank),
    .fill_start_i   (fill_start),
    .fill_value_i   (fill_value),
    .fill_busy_o    (fill_busy),
    .fill_done_o    (fill_done),
    .host_starved_o (host_starved),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_pix(input int a);
    if (a == 5) return 8'hA5;
    return 8'(a) ^ 8'h5A;
  endfunction

  // RAM harness: unwritten locations read back their initial pattern.
  logic [7:0] ram     [DEPTH];
  bit         wr_mark [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_en && (bus.mem_addr < ADDR_W'(DEPTH))) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]     <= bus.mem_wdata;
        wr_mark[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= wr_mark[bus.mem_addr] ? ram[bus.mem_addr] : init_pix(int'(bus.mem_addr));
      end
    end
  end

  function automatic logic [7:0] ram_read(input int a);
    return wr_mark[a] ? ram[a] : init_pix(a);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame contents plus fill progress / host streak bookkeeping.
  logic [7:0] ref_mem [DEPTH];
  int         fill_left;
  int         fill_next;
  logic [7:0] fill_val;
  bit         done_now;
  int         streak;
  bit         pend_rd;
  logic [7:0] pend_data;
  logic       obs_busy, obs_done, obs_ready, obs_starved;

  task automatic model_reset();
    fill_left = 0;
    fill_next = 0;
    done_now  = 1'b0;
    streak    = 0;
    pend_rd   = 1'b0;
  endtask

  task automatic drive(input bit dreq, input int daddr, input bit wv, input int waddr,
                       input logic [7:0] wd, input bit fs, input logic [7:0] fv);
    bus.disp_req  = dreq;
    bus.disp_addr = ADDR_W'(daddr);
    bus.wr_valid  = wv;
    bus.wr_addr   = ADDR_W'(waddr);
    bus.wr_data   = wd;
    fill_start    = fs;
    fill_value    = fv;
  endtask

  // One clock of stimulus; called and returns at posedge+1.
  task automatic run_cycle(input bit dreq, input int daddr, input bit wv, input int waddr,
                           input logic [7:0] wd, input bit fs, input logic [7:0] fv);
    bit exp_busy, exp_ready, fill_wr, host_wr, exp_en, exp_we, start_ok;
    int exp_addr;
    logic [7:0] exp_wd;
    drive(dreq, daddr, wv, waddr, wd, fs, fv);
    @(negedge clk);
    exp_busy  = (fill_left > 0);
    exp_ready = !dreq && !exp_busy;
    fill_wr   = exp_busy && !dreq;
    host_wr   = wv && exp_ready;
    exp_en    = dreq || fill_wr || host_wr;
    exp_we    = fill_wr || host_wr;
    exp_addr  = dreq ? daddr : (fill_wr ? fill_next : waddr);
    exp_wd    = fill_wr ? fill_val : wd;
    obs_busy = fill_busy; obs_done = fill_done; obs_ready = bus.wr_ready; obs_starved = host_starved;
    chk("wr_ready", bus.wr_ready, exp_ready);
    chk("fill_busy", fill_busy, exp_busy);
    chk("fill_done", fill_done, done_now);
    chk("host_starved", host_starved, streak >= LIMIT);
    chk("mem_en", bus.mem_en, exp_en);
    chk("mem_we", bus.mem_we, exp_we);
    if (exp_en) chk("mem_addr", bus.mem_addr, exp_addr);
    if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wd);
    chk("disp_valid", bus.disp_valid, pend_rd);
    if (pend_rd) chk("disp_data", bus.disp_data, pend_data);
    start_ok = fs && !exp_busy && !done_now;
    pend_rd  = dreq;
    if (dreq) pend_data = ref_mem[daddr];
    done_now = 1'b0;
    if (fill_wr) begin
      ref_mem[fill_next] = fill_val;
      fill_next++;
      fill_left--;
      if (fill_left == 0) done_now = 1'b1;
    end else if (host_wr) begin
      ref_mem[waddr] = wd;
    end
    if (start_ok) begin
      fill_left = DEPTH;
      fill_next = 0;
      fill_val  = fv;
    end
    streak = (wv && !exp_ready) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit dreq; int daddr; bit wv; int waddr; logic [7:0] wd;
    bit rdy; bit en; bit we; int maddr; logic [7:0] mwd; bit dv; logic [7:0] dd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int first_rise, busy_cnt, done_cnt, rdy_busy, bad, bad_addr;
    bit done_seen;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pix(i);
    model_reset();

    // Reset with every requester active: memory must stay untouched.
    drive(1, 5, 1, 3, 8'h11, 1, 8'h22);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_disp_valid", bus.disp_valid, 0);
    chk("reset_fill_busy", fill_busy, 0);
    chk("reset_fill_done", fill_done, 0);
    chk("reset_host_starved", host_starved, 0);
    $display("reset: outputs checked while rst_n low");
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arbitration / read-latency vectors (disp fields refer to the previous row's request).
    vecs[0] = '{0, 0,       0, 0,   8'h00, 1, 0, 0, 0,       8'h00, 0, 8'h00};
    vecs[1] = '{1, 5,       0, 0,   8'h00, 0, 1, 0, 5,       8'h00, 0, 8'h00};
    vecs[2] = '{1, 7,       1, 100, 8'h3C, 0, 1, 0, 7,       8'h00, 1, 8'hA5};
    vecs[3] = '{0, 0,       1, 100, 8'h3C, 1, 1, 1, 100,     8'h3C, 1, 8'h5D};
    vecs[4] = '{1, 100,     0, 0,   8'h00, 0, 1, 0, 100,     8'h00, 0, 8'h00};
    vecs[5] = '{0, 0,       0, 0,   8'h00, 1, 0, 0, 0,       8'h00, 1, 8'h3C};
    vecs[6] = '{1, DEPTH-1, 1, 0,   8'hFF, 0, 1, 0, DEPTH-1, 8'h00, 0, 8'h00};
    vecs[7] = '{0, 0,       1, 0,   8'hFF, 1, 1, 1, 0,       8'hFF, 1, 8'hA5};
    vecs[8] = '{1, 0,       0, 0,   8'h00, 0, 1, 0, 0,       8'h00, 0, 8'h00};
    vecs[9] = '{0, 0,       0, 0,   8'h00, 1, 0, 0, 0,       8'h00, 1, 8'hFF};

    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].dreq, vecs[v].daddr, vecs[v].wv, vecs[v].waddr, vecs[v].wd, 0, 8'h00);
      @(negedge clk);
      chk("vec_wr_ready", bus.wr_ready, vecs[v].rdy);
      chk("vec_mem_en", bus.mem_en, vecs[v].en);
      chk("vec_mem_we", bus.mem_we, vecs[v].we);
      if (vecs[v].en) chk("vec_mem_addr", bus.mem_addr, vecs[v].maddr);
      if (vecs[v].we) chk("vec_mem_wdata", bus.mem_wdata, vecs[v].mwd);
      chk("vec_disp_valid", bus.disp_valid, vecs[v].dv);
      if (vecs[v].dv) chk("vec_disp_data", bus.disp_data, vecs[v].dd);
      if (vecs[v].we) ref_mem[vecs[v].maddr] = vecs[v].mwd;
      $display("vec %0d: dreq=%0d daddr=%0d wv=%0d waddr=%0d wd=%02h", v,
               vecs[v].dreq, vecs[v].daddr, vecs[v].wv, vecs[v].waddr, vecs[v].wd);
      @(posedge clk);
      #1;
    end

    // Starvation: host blocked by a held display request.
    run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    first_rise = -1;
    for (int i = 0; i < 1100; i++) begin
      run_cycle(1, $urandom_range(DEPTH-1), 1, 200, 8'h11, 0, 8'h00);
      if (obs_starved && first_rise < 0) first_rise = i;
    end
    chk("starve_rise_cycle", first_rise, 1024);
    run_cycle(0, 0, 1, 200, 8'h11, 0, 8'h00);
    chk("starve_hold_on_accept", obs_starved, 1);
    run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    chk("starve_clear_after_accept", obs_starved, 0);
    $display("starvation: first_rise=%0d", first_rise);

    // Randomised display/host traffic, no fill.
    for (int i = 0; i < 3000; i++) begin
      run_cycle($urandom_range(1), $urandom_range(DEPTH-1), $urandom_range(9) < 6,
                $urandom_range(DEPTH-1), 8'($urandom), 0, 8'h00);
    end
    $display("random: 3000 cycles of display/host traffic");

    // Full fill with no display traffic; a start during DONE must be ignored.
    busy_cnt = 0; done_cnt = 0; done_seen = 1'b0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      run_cycle(0, 0, 0, 0, 8'h00, (c == 0) || done_now, (c == 0) ? 8'h80 : 8'h11);
      if (obs_busy) busy_cnt++;
      if (obs_done) begin done_cnt++; done_seen = 1'b1; break; end
    end
    for (int c = 0; c < 3; c++) begin
      run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
      if (obs_done) done_cnt++;
    end
    chk("fill3_done_seen", done_seen, 1);
    chk("fill3_busy_cycles", busy_cnt, DEPTH);
    chk("fill3_done_pulses", done_cnt, 1);
    bad = 0; bad_addr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram_read(i) !== 8'h80) begin
        bad++;
        if (bad_addr < 0) bad_addr = i;
      end
    end
    chk("fill3_all_locations", bad, 0);
    $display("fill: busy=%0d done=%0d bad=%0d first_bad=%0d", busy_cnt, done_cnt, bad, bad_addr);

    // Fill interleaved with display every other cycle, host waiting throughout.
    busy_cnt = 0; rdy_busy = 0; done_seen = 1'b0;
    for (int c = 0; c < 2 * DEPTH + 20; c++) begin
      run_cycle((c % 2) == 1, $urandom_range(DEPTH-1), 1, $urandom_range(DEPTH-1),
                8'($urandom), (c == 0) || ($urandom_range(499) == 0), 8'h3C);
      if (obs_busy) busy_cnt++;
      if (obs_busy && obs_ready) rdy_busy++;
      if (obs_done) begin done_seen = 1'b1; break; end
    end
    chk("fill4_done_seen", done_seen, 1);
    chk("fill4_busy_cycles", busy_cnt, 2 * DEPTH);
    chk("fill4_ready_while_busy", rdy_busy, 0);
    run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    $display("fill interleaved: busy=%0d ready_while_busy=%0d", busy_cnt, rdy_busy);

    // Reset in the middle of a fill, then restart from address 0.
    run_cycle(0, 0, 0, 0, 8'h00, 1, 8'h77);
    for (int c = 0; c < 600 && fill_next < 500; c++) run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    chk("rst6_reached_500", fill_next, 500);
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);
    #1;
    chk("rst6_pre_mem_en", bus.mem_en, 1);
    chk("rst6_pre_mem_addr", bus.mem_addr, 500);
    rst_n = 1'b0;
    #1;
    chk("rst6_fill_busy", fill_busy, 0);
    chk("rst6_mem_en", bus.mem_en, 0);
    chk("rst6_mem_we", bus.mem_we, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    run_cycle(0, 0, 0, 0, 8'h00, 1, 8'h42);
    for (int c = 0; c < 16; c++) run_cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
    chk("rst6_restart_progress", fill_next, 16);
    chk("rst6_addr0_value", ram_read(0), 8'h42);
    $display("reset mid-fill: restart progressed to %0d", fill_next);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
